// File: rtl/ycc_mcu_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ycc_mcu_sched_if
// Description : Bundle of the MCU scheduler's sample input stream, the
//               downstream stall and the colour-converter drive outputs.
//               slave  - used by ycc_mcu_sched
//               master - used by whoever drives samples / consumes pixels
// Signals     : in_vld/in_data/in_rdy  IDCT sample handshake (8-bit samples)
//               stall                  downstream hold
//               cc_y/cc_cb/cc_cr/cc_vld converter drive
//               px_x/px_y              pixel column/row within the MCU
//               mcu_done/mcu_cnt       end-of-MCU pulse, drained MCU count
// Revision    : 1.0 - initial release
// ============================================================================
interface ycc_mcu_sched_if #(
  parameter int MCU_CW = 16
);
  logic              in_vld;
  logic [7:0]        in_data;
  logic              in_rdy;
  logic              stall;
  logic [7:0]        cc_y;
  logic [7:0]        cc_cb;
  logic [7:0]        cc_cr;
  logic              cc_vld;
  logic [3:0]        px_x;
  logic [3:0]        px_y;
  logic              mcu_done;
  logic [MCU_CW-1:0] mcu_cnt;

  modport slave (
    input  in_vld, in_data, stall,
    output in_rdy, cc_y, cc_cb, cc_cr, cc_vld, px_x, px_y, mcu_done, mcu_cnt
  );

  modport master (
    output in_vld, in_data, stall,
    input  in_rdy, cc_y, cc_cb, cc_cr, cc_vld, px_x, px_y, mcu_done, mcu_cnt
  );
endinterface
`default_nettype wire

// File: rtl/ycc_mcu_sched.sv
`default_nettype none
// ============================================================================
// Module      : ycc_mcu_sched
// Description : Buffers one decoded MCU (Y blocks, Cb, Cr from the IDCT) and
//               drains it in raster order into the YCbCr->RGB converter,
//               replicating each chroma sample over a 2x2 pixel area in
//               4:2:0 mode.
// Parameters  : SUB420  1: 4:2:0 MCU (Y0..Y3,Cb,Cr, 16x16); 0: 4:4:4 (8x8)
//               MCU_CW  width of the drained-MCU counter
// Macro       : MCU_PINGPONG_EN - two RAM banks, fill and drain overlap.
//               Undefined: single bank, strict FILL/DRAIN alternation.
// Ports       : clk   rising-edge clock
//               rstn  asynchronous active-low reset
//               io    ycc_mcu_sched_if.slave (sample input, stall,
//                     converter outputs, pixel position, MCU status)
// Revision    : 1.0 - initial release
// ============================================================================
module ycc_mcu_sched #(
  parameter int SUB420 = 1,
  parameter int MCU_CW = 16
) (
  input wire             clk,
  input wire             rstn,
  ycc_mcu_sched_if.slave io
);

  localparam int         c_NPIX    = (SUB420 != 0) ? 256 : 64;
  localparam logic [8:0] c_WLAST   = 9'(c_NPIX + 128 - 1);
  localparam logic [7:0] c_RLAST   = 8'(c_NPIX - 1);
  localparam logic [8:0] c_CB_BASE = 9'(c_NPIX);
  localparam logic [8:0] c_CR_BASE = 9'(c_NPIX + 64);

  // Storage; the top address bit selects the bank (tied low without ping-pong)
  logic [7:0] r_ymem  [512];
  logic [7:0] r_cbmem [128];
  logic [7:0] r_crmem [128];

  logic [8:0]        r_wcnt;
  logic [7:0]        r_rcnt;
  logic [7:0]        r_cc_y, r_cc_cb, r_cc_cr;
  logic [3:0]        r_px_x, r_px_y;
  logic              r_cc_vld, r_mcu_done;
  logic [MCU_CW-1:0] r_mcu_cnt;

  logic       w_wbank, w_rbank, w_can_wr, w_can_rd;
  logic       w_wr, w_wlast, w_iss, w_rlast;
  logic [3:0] w_row, w_col;
  logic [7:0] w_yra;
  logic [5:0] w_cra;

  assign w_wr    = io.in_vld && w_can_wr;
  assign w_wlast = (r_wcnt == c_WLAST);
  assign w_iss   = w_can_rd && !io.stall;
  assign w_rlast = (r_rcnt == c_RLAST);

`ifdef MCU_PINGPONG_EN
  logic [1:0] r_full;
  logic       r_wbank, r_rbank;

  assign w_wbank  = r_wbank;
  assign w_rbank  = r_rbank;
  assign w_can_wr = !r_full[r_wbank];
  assign w_can_rd = r_full[r_rbank];

  // A write can only target an empty bank and an issue only a full one, so a
  // same-cycle set and clear always land on different banks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full  <= 2'b00;
      r_wbank <= 1'b0;
      r_rbank <= 1'b0;
    end else begin
      if (w_wr && w_wlast) begin
        r_full[r_wbank] <= 1'b1;
        r_wbank         <= ~r_wbank;
      end
      if (w_iss && w_rlast) begin
        r_full[r_rbank] <= 1'b0;
        r_rbank         <= ~r_rbank;
      end
    end
  end
`else
  typedef enum logic [0:0] {
    S_FILL  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t r_state;

  assign w_wbank  = 1'b0;
  assign w_rbank  = 1'b0;
  assign w_can_wr = (r_state == S_FILL);
  assign w_can_rd = (r_state == S_DRAIN);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_FILL;
    end else if (w_wr && w_wlast) begin
      r_state <= S_DRAIN;
    end else if (w_iss && w_rlast) begin
      r_state <= S_FILL;
    end
  end
`endif

  // Raster position to RAM addresses. In 4:2:0 the Y RAM holds four 8x8
  // blocks in TL,TR,BL,BR order, so the block index is {row[3],col[3]};
  // chroma is addressed at half resolution.
  always_comb begin
    if (SUB420 != 0) begin
      w_row = r_rcnt[7:4];
      w_col = r_rcnt[3:0];
      w_yra = {w_row[3], w_col[3], w_row[2:0], w_col[2:0]};
      w_cra = {w_row[3:1], w_col[3:1]};
    end else begin
      w_row = {1'b0, r_rcnt[5:3]};
      w_col = {1'b0, r_rcnt[2:0]};
      w_yra = {2'b00, r_rcnt[5:0]};
      w_cra = r_rcnt[5:0];
    end
  end

  // Sample writes: Y, Cb and Cr regions start on 64-sample boundaries, so
  // the low write-count bits are the in-block address.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      if (r_wcnt < c_CB_BASE) begin
        r_ymem[{w_wbank, r_wcnt[7:0]}] <= io.in_data;
      end else if (r_wcnt < c_CR_BASE) begin
        r_cbmem[{w_wbank, r_wcnt[5:0]}] <= io.in_data;
      end else begin
        r_crmem[{w_wbank, r_wcnt[5:0]}] <= io.in_data;
      end
    end
  end

  // Counters and the registered read/output stage. Data and position only
  // move on an issue, so they hold through stall cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_cc_y     <= '0;
      r_cc_cb    <= '0;
      r_cc_cr    <= '0;
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_cc_vld   <= 1'b0;
      r_mcu_done <= 1'b0;
      r_mcu_cnt  <= '0;
    end else begin
      r_cc_vld   <= w_iss;
      r_mcu_done <= w_iss && w_rlast;
      if (w_wr) begin
        r_wcnt <= w_wlast ? 9'd0 : r_wcnt + 9'd1;
      end
      if (w_iss) begin
        r_rcnt  <= w_rlast ? 8'd0 : r_rcnt + 8'd1;
        r_cc_y  <= r_ymem[{w_rbank, w_yra}];
        r_cc_cb <= r_cbmem[{w_rbank, w_cra}];
        r_cc_cr <= r_crmem[{w_rbank, w_cra}];
        r_px_x  <= w_col;
        r_px_y  <= w_row;
        if (w_rlast) begin
          r_mcu_cnt <= r_mcu_cnt + MCU_CW'(1);
        end
      end
    end
  end

  assign io.in_rdy   = w_can_wr;
  assign io.cc_y     = r_cc_y;
  assign io.cc_cb    = r_cc_cb;
  assign io.cc_cr    = r_cc_cr;
  assign io.cc_vld   = r_cc_vld;
  assign io.px_x     = r_px_x;
  assign io.px_y     = r_px_y;
  assign io.mcu_done = r_mcu_done;
  assign io.mcu_cnt  = r_mcu_cnt;

endmodule
`default_nettype wire
